// File: rtl/linebuf_kxk_win.sv
// Streaming K x K window generator: K-1 line buffers feed a K x K shift array.
// Optional LINEBUF_POS_EN adds out_col/out_row giving the position of the newest tap.
module linebuf_kxk_win #(
  parameter int K         = 3,
  parameter int MAX_WIDTH = 256,
  parameter int BITW      = 8,
  localparam int WW       = $clog2(MAX_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WW-1:0]         img_width,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [BITW-1:0]       in_pix,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K*K*BITW-1:0]   out_win,
  output logic                  cfg_err
`ifdef LINEBUF_POS_EN
  ,
  output logic [WW-1:0]         out_col,
  output logic [15:0]           out_row
`endif
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int RW = $clog2(K);

  logic [AW-1:0] col, c_eff, col_nxt;
  logic [RW-1:0] row, r_eff, row_nxt;
  logic [WW-1:0] width_q, w_eff;
  logic          sof_seen, bad, acc, wrap, win_ok, w_bad;

  logic [BITW-1:0]                   lb [K-1][MAX_WIDTH];
  logic [K-1:0][K-1:0][BITW-1:0]     sh, sh_nxt;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // An accepted SOF pixel is always (0,0) of a fresh frame.
  assign c_eff   = in_sof ? '0 : col;
  assign r_eff   = in_sof ? '0 : row;
  assign w_eff   = in_sof ? img_width : width_q;
  assign w_bad   = (img_width < WW'(K)) || (img_width > WW'(MAX_WIDTH));
  // Second term keeps an illegal width from walking col off the end of the RAM.
  assign wrap    = (WW'(c_eff) == w_eff - WW'(1)) || (c_eff == AW'(MAX_WIDTH - 1));
  assign col_nxt = wrap ? '0 : c_eff + AW'(1);
  assign row_nxt = (wrap && r_eff != RW'(K - 1)) ? r_eff + RW'(1) : r_eff;
  assign win_ok  = (in_sof ? !w_bad : (sof_seen && !bad))
                   && (r_eff >= RW'(K - 1)) && (c_eff >= AW'(K - 1));

  always_comb begin
    sh_nxt = sh;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) sh_nxt[i][j] = sh[i][j+1];
    end
    for (int i = 0; i < K - 1; i++) sh_nxt[i][K-1] = lb[K-2-i][c_eff];
    sh_nxt[K-1][K-1] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][c_eff] <= in_pix;
      for (int i = 1; i < K - 1; i++) lb[i][c_eff] <= lb[i-1][c_eff];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      width_q   <= '0;
      sof_seen  <= 1'b0;
      bad       <= 1'b0;
      cfg_err   <= 1'b0;
      sh        <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
    end else begin
      if (acc) begin
        col <= col_nxt;
        row <= row_nxt;
        sh  <= sh_nxt;
        if (in_sof) begin
          width_q  <= img_width;
          sof_seen <= 1'b1;
          bad      <= w_bad;
          if (w_bad) cfg_err <= 1'b1;
        end
      end
      if (acc && win_ok) begin
        out_valid <= 1'b1;
        out_win   <= sh_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LINEBUF_POS_EN
  logic [15:0] row_full, rf_eff;

  assign rf_eff = in_sof ? '0 : row_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_full <= '0;
      out_col  <= '0;
      out_row  <= '0;
    end else if (acc) begin
      row_full <= wrap ? rf_eff + 16'd1 : rf_eff;
      if (win_ok) begin
        out_col <= WW'(c_eff);
        out_row <= rf_eff;
      end
    end
  end
`endif

endmodule

// File: tb/tb_linebuf_kxk_win.sv
// Scoreboard bench for linebuf_kxk_win: a K=3 and a K=5 instance driven with ramp frames.
module tb_linebuf_kxk_win;

  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]   img_width;
  logic         in_sof;
  logic [7:0]   in_pix;
  logic         vld3, vld5, ordy3, ordy5;
  logic         rdy3, rdy5, ov3, ov5, err3, err5;
  logic [71:0]  win3;
  logic [199:0] win5;

  linebuf_kxk_win #(.K(3), .MAX_WIDTH(MW), .BITW(8)) u_k3 (
    .clk(clk), .rst_n(rst_n), .img_width(img_width), .in_valid(vld3), .in_ready(rdy3),
    .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov3), .out_ready(ordy3),
    .out_win(win3), .cfg_err(err3)
  );

  linebuf_kxk_win #(.K(5), .MAX_WIDTH(MW), .BITW(8)) u_k5 (
    .clk(clk), .rst_n(rst_n), .img_width(img_width), .in_valid(vld5), .in_ready(rdy5),
    .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov5), .out_ready(ordy5),
    .out_win(win5), .cfg_err(err5)
  );

  logic [199:0] q3[$];
  logic [199:0] q5[$];
  int checks = 0;
  int passes = 0;
  int cnt3 = 0;
  int cnt5 = 0;

  task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Ramp frame: pixel (r,c) = r*w + c, so tap (i,j) of the window ending at (r,c) is known.
  function automatic logic [199:0] exp_win(int k, int w, int r, int c);
    logic [199:0] v = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        v[(i*k+j)*8 +: 8] = 8'((r - k + 1 + i) * w + (c - k + 1 + j));
    return v;
  endfunction

  always @(negedge clk) begin
    #2;
    if (rst_n && ov3 && ordy3) begin
      if (q3.size() == 0) begin
        checks++;
        $display("FAIL k3_unexpected_window: got %0h, none expected", win3);
      end else begin
        chk("k3_window", {128'b0, win3}, q3.pop_front());
        cnt3++;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && ov5 && ordy5) begin
      if (q5.size() == 0) begin
        checks++;
        $display("FAIL k5_unexpected_window: got %0h, none expected", win5);
      end else begin
        chk("k5_window", win5, q5.pop_front());
        cnt5++;
      end
    end
  end

  task automatic send_px(int sel, int r, int c, int w, bit sof, bit ok);
    int n = 0;
    int k = (sel == 3) ? 3 : 5;
    @(negedge clk);
    in_pix    = 8'(r * w + c);
    in_sof    = sof;
    img_width = 5'(w);
    if (sel == 3) vld3 = 1'b1; else vld5 = 1'b1;
    #1;
    while (((sel == 3) ? rdy3 : rdy5) == 1'b0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, required 1");
    end
    if (ok && r >= k - 1 && c >= k - 1) begin
      if (sel == 3) q3.push_back(exp_win(k, w, r, c));
      else q5.push_back(exp_win(k, w, r, c));
    end
    @(posedge clk);
    #1;
    vld3   = 1'b0;
    vld5   = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic send_row(int sel, int w, int r, int c0, int c1, bit ok);
    for (int c = c0; c <= c1; c++) send_px(sel, r, c, w, (r == 0 && c == 0), ok);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #3;
  endtask

  initial begin
    int base;
    vld3 = 0; vld5 = 0; ordy3 = 1; ordy5 = 1;
    in_sof = 0; in_pix = 0; img_width = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", rdy3, 1);
    chk("reset_out_valid_k3", ov3, 0);
    chk("reset_out_valid_k5", ov5, 0);
    chk("reset_cfg_err", err3, 0);
    chk("reset_out_win", win3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pixels before any SOF are swallowed.
    for (int c = 0; c < 5; c++) send_px(3, 0, c, 8, 0, 0);
    settle();
    chk("pre_sof_windows", cnt3, 0);

    // K=3, width 8 ramp.
    for (int r = 0; r < 4; r++) begin
      base = cnt3;
      for (int c = 0; c < 8; c++) begin
        send_px(3, r, c, 8, (r == 0 && c == 0), 1);
        if (r == 2 && c == 2) begin
          chk("first_win_valid", ov3, 1);
          chk("first_win_taps", win3, 72'h121110_0A0908_020100);
        end
      end
      settle();
      chk("k3_windows_per_line", cnt3 - base, (r >= 2) ? 6 : 0);
    end

    // Backpressure: hold the (2,2) window for 5 cycles while pixel (2,3) waits.
    send_row(3, 8, 0, 0, 7, 1);
    send_row(3, 8, 1, 0, 7, 1);
    send_row(3, 8, 2, 0, 2, 1);
    @(negedge clk);
    ordy3 = 1'b0; vld3 = 1'b1; in_pix = 8'(2 * 8 + 3);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", rdy3, 0);
      chk("stall_hold_valid", ov3, 1);
      chk("stall_hold_win", win3, exp_win(3, 8, 2, 2));
    end
    @(negedge clk);
    vld3 = 1'b0; ordy3 = 1'b1;
    send_row(3, 8, 2, 3, 7, 1);
    send_row(3, 8, 3, 0, 4, 1);
    settle();

    // SOF at old (3,5) restarts the frame.
    base = cnt3;
    send_row(3, 8, 0, 0, 7, 1);
    send_row(3, 8, 1, 0, 7, 1);
    settle();
    chk("no_win_after_mid_sof", cnt3 - base, 0);
    send_row(3, 8, 2, 0, 7, 1);
    settle();
    chk("win_after_mid_sof", cnt3 - base, 6);

    // Illegal width 2 flags cfg_err and produces nothing; a legal frame then recovers.
    base = cnt3;
    for (int r = 0; r < 3; r++) send_row(3, 2, r, 0, 1, 0);
    settle();
    chk("cfg_err_set", err3, 1);
    chk("bad_width_no_windows", cnt3 - base, 0);
    for (int r = 0; r < 3; r++) send_row(3, 4, r, 0, 3, 1);
    settle();
    chk("cfg_err_sticky", err3, 1);
    chk("legal_after_bad_windows", cnt3 - base, 2);

    // Reset mid-line with a held window.
    send_row(3, 8, 0, 0, 7, 1);
    send_row(3, 8, 1, 0, 7, 1);
    send_row(3, 8, 2, 0, 2, 1);
    @(negedge clk);
    ordy3 = 1'b0;
    #3;
    chk("held_before_reset", ov3, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", ov3, 0);
    chk("rst_cfg_err", err3, 0);
    chk("rst_pending_windows", q3.size(), 1);
    q3.delete();
    @(negedge clk);
    rst_n = 1'b1; ordy3 = 1'b1;
    #1;
    chk("rst_in_ready", rdy3, 1);
    base = cnt3;
    for (int c = 3; c < 8; c++) send_px(3, 2, c, 8, 0, 0);
    settle();
    chk("post_rst_no_windows", cnt3 - base, 0);
    for (int r = 0; r < 3; r++) send_row(3, 8, r, 0, 7, 1);
    settle();
    chk("post_rst_frame_windows", cnt3 - base, 6);

    // K=5, width 16 ramp.
    for (int r = 0; r < 6; r++) begin
      base = cnt5;
      for (int c = 0; c < 16; c++) begin
        send_px(5, r, c, 16, (r == 0 && c == 0), 1);
        if (r == 4 && c == 4) begin
          chk("k5_first_valid", ov5, 1);
          chk("k5_tap00", win5[7:0], 0);
          chk("k5_tap44", win5[24*8 +: 8], 68);
        end
      end
      settle();
      chk("k5_windows_per_line", cnt5 - base, (r >= 4) ? 12 : 0);
    end

    settle();
    chk("k3_queue_drained", q3.size(), 0);
    chk("k5_queue_drained", q5.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
